// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// Round-robin arbiter that shares a single memory/bus target between
// N_CLIENTS client control blocks. One requester is picked at a time. Its
// address, write data and write_n are registered onto the shared bus. The
// arbiter then waits for the target's ready, or gives up after TIMEOUT
// cycles, and returns a one-cycle ack with read data and an error flag to
// that client.
//
// Every output comes straight from a flop (Moore style). One transfer walks
// through IDLE -> GRANT -> XFER -> ACK -> RECOVER -> IDLE.
//
// Parameters
//   N_CLIENTS  number of clients (2..8)
//   ADDR_W     bus / client address width
//   DATA_W     bus / client data width
//   TIMEOUT    max cycles bus_valid is held without bus_ready (>= 1)
//
// Ports
//   clk        clock
//   rstn       asynchronous active-low reset
//   rq         per-client request, level sensitive, sampled only in IDLE
//   cl_addr    client addresses, client i at [i*ADDR_W +: ADDR_W]
//   cl_wdata   client write data, client i at [i*DATA_W +: DATA_W]
//   cl_wr_ni   client write_n (0 = write, 1 = read)
//   gnt        one-hot grant, high from GRANT through ACK
//   ack        one-cycle completion pulse to the granted client
//   rdata      read data, valid while ack is high
//   err        timeout flag, valid while ack is high
//   bus_valid  transfer request to the target (high only in XFER)
//   bus_addr   registered bus address
//   bus_wdata  registered bus write data
//   bus_wr_n   registered bus write_n
//   bus_ready  target completion; bus_rdata is valid in the same cycle
//   bus_rdata  target read data
// ---------------------------------------------------------------------------
module bus_arbiter #(
    parameter int N_CLIENTS = 4,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [N_CLIENTS-1:0]        rq,
    input  logic [N_CLIENTS*ADDR_W-1:0] cl_addr,
    input  logic [N_CLIENTS*DATA_W-1:0] cl_wdata,
    input  logic [N_CLIENTS-1:0]        cl_wr_ni,
    output logic [N_CLIENTS-1:0]        gnt,
    output logic [N_CLIENTS-1:0]        ack,
    output logic [DATA_W-1:0]           rdata,
    output logic                        err,
    output logic                        bus_valid,
    output logic [ADDR_W-1:0]           bus_addr,
    output logic [DATA_W-1:0]           bus_wdata,
    output logic                        bus_wr_n,
    input  logic                        bus_ready,
    input  logic [DATA_W-1:0]           bus_rdata
);

    // -----------------------------------------------------------------------
    // Local parameters
    // -----------------------------------------------------------------------
    // Width of a client index.
    localparam int IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

    // The wait counter gets one spare bit above what TIMEOUT-1 needs. The
    // abort compare then stays trivially in range, and the counter can
    // never wrap.
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    // After reset the pointer sits on the highest client, so the first scan
    // starts at client 0.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLIENTS - 1);

    // The counter value seen in the TIMEOUT-th bus_valid cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // N_CLIENTS in the one-bit-wider width used for the modulo wrap.
    localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(N_CLIENTS);

    // -----------------------------------------------------------------------
    // FSM encoding
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT   = 3'd1,
        XFER    = 3'd2,
        ACK     = 3'd3,
        RECOVER = 3'd4
    } state_t;

    // -----------------------------------------------------------------------
    // State: flop outputs (_q) and their next values (_d)
    // -----------------------------------------------------------------------
    state_t                 state_q,      state_d;
    logic [IDX_W-1:0]       last_grant_q, last_grant_d;
    logic [CNT_W-1:0]       wait_cnt_q,   wait_cnt_d;
    logic [N_CLIENTS-1:0]   gnt_q,        gnt_d;
    logic [N_CLIENTS-1:0]   ack_q,        ack_d;
    logic [DATA_W-1:0]      rdata_q,      rdata_d;
    logic                   err_q,        err_d;
    logic                   bus_valid_q,  bus_valid_d;
    logic [ADDR_W-1:0]      bus_addr_q,   bus_addr_d;
    logic [DATA_W-1:0]      bus_wdata_q,  bus_wdata_d;
    logic                   bus_wr_n_q,   bus_wr_n_d;

    // Round-robin winner among the current requesters.
    logic [IDX_W-1:0]       rr_winner;

    // Client fields unpacked into arrays so that a client index can pick
    // them directly.
    logic [ADDR_W-1:0]      cl_addr_arr  [N_CLIENTS];
    logic [DATA_W-1:0]      cl_wdata_arr [N_CLIENTS];

    for (genvar i = 0; i < N_CLIENTS; i++) begin : g_unpack
        assign cl_addr_arr[i]  = cl_addr[i*ADDR_W +: ADDR_W];
        assign cl_wdata_arr[i] = cl_wdata[i*DATA_W +: DATA_W];
    end

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------

    // Returns the first requester found when scanning last+1, last+2, ...
    // modulo N_CLIENTS. The scan covers every client, and the last one
    // checked is 'last' itself. A client that keeps its request high is
    // therefore served again only after every other active requester ahead
    // of it. The result is meaningful only when 'req' is non-zero.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [IDX_W-1:0]     last,
        input logic [N_CLIENTS-1:0] req
    );
        logic [IDX_W:0]   cand;
        logic [IDX_W-1:0] pick;
        logic             found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= N_CLIENTS; k++) begin
            // last + k is at most 2*N_CLIENTS-1, so a single subtraction
            // is enough to wrap it back into range.
            cand = {1'b0, last} + (IDX_W + 1)'(k);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDX_W-1:0];
            end
        end
        return pick;
    endfunction

    // One-hot vector with bit 'idx' set.
    function automatic logic [N_CLIENTS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_CLIENTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign rr_winner = rr_pick(last_grant_q, rq);

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal this block drives is given a default first. No
        // path through the case statement can then leave one unassigned,
        // so no latch is inferred.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wait_cnt_d   = wait_cnt_q;
        gnt_d        = gnt_q;
        ack_d        = '0;          // ack is a pulse; only XFER->ACK sets it
        rdata_d      = rdata_q;
        err_d        = err_q;
        bus_valid_d  = 1'b0;        // high only while the next state is XFER
        bus_addr_d   = bus_addr_q;  // bus fields hold outside GRANT
        bus_wdata_d  = bus_wdata_q;
        bus_wr_n_d   = bus_wr_n_q;

        case (state_q)
            IDLE: begin
                // rq is looked at only here; requests seen in any other
                // state have no effect.
                if (|rq) begin
                    state_d      = GRANT;
                    gnt_d        = onehot(rr_winner);
                    last_grant_d = rr_winner;
                end
            end

            GRANT: begin
                // The winner's fields are captured once, here. Later
                // changes on cl_* do not disturb the transfer in flight.
                bus_addr_d  = cl_addr_arr[last_grant_q];
                bus_wdata_d = cl_wdata_arr[last_grant_q];
                bus_wr_n_d  = cl_wr_ni[last_grant_q];
                wait_cnt_d  = '0;
                bus_valid_d = 1'b1;
                state_d     = XFER;
            end

            XFER: begin
                if (bus_ready) begin
                    // Success takes priority over the timeout. A ready that
                    // arrives in the last allowed cycle is still a good
                    // completion. rdata is captured on writes too.
                    state_d = ACK;
                    ack_d   = onehot(last_grant_q);
                    rdata_d = bus_rdata;
                    err_d   = 1'b0;
                end else if (wait_cnt_q == CNT_LAST) begin
                    // bus_valid has now been high for TIMEOUT cycles.
                    state_d = ACK;
                    ack_d   = onehot(last_grant_q);
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d  = wait_cnt_q + CNT_W'(1);
                    bus_valid_d = 1'b1;
                end
            end

            ACK: begin
                // gnt has covered the ack cycle and is dropped here.
                gnt_d   = '0;
                state_d = RECOVER;
            end

            RECOVER: begin
                // One dead cycle lets the client drop or renew rq before
                // the next arbitration.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the bus fields are plain flops, not storage arrays.
            // Resetting them gives the target a defined, inert bus
            // (read, address 0) from reset onward.
            state_q      <= IDLE;
            last_grant_q <= LAST_IDX;
            wait_cnt_q   <= '0;
            gnt_q        <= '0;
            ack_q        <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            bus_valid_q  <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_wr_n_q   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make all flops update together
            // from the same pre-edge values. Blocking assignments here would
            // make the result depend on statement order.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
            gnt_q        <= gnt_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            bus_valid_q  <= bus_valid_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_wr_n_q   <= bus_wr_n_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: every one is a flop
    // -----------------------------------------------------------------------
    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign bus_valid = bus_valid_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wr_n  = bus_wr_n_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//
// Self-checking bench for bus_arbiter with the default parameters
// (4 clients, 8-bit address and data, TIMEOUT = 16).
//
// Inputs change on the falling clock edge. Outputs are sampled on the
// falling edge, halfway between the rising edges where the DUT updates. A
// table of per-cycle vectors covers single transfers, a delayed write,
// request handling in RECOVER and a request dropped during GRANT.
// Hand-written sequences cover round-robin fairness, timeout, ready in the
// last allowed cycle, and reset during a transfer.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int TO    = 16;
    localparam int N_VEC = 25;

    logic        clk;
    logic        rstn;
    logic [3:0]  rq;
    logic [31:0] cl_addr;
    logic [31:0] cl_wdata;
    logic [3:0]  cl_wr_ni;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  rdata;
    logic        err;
    logic        bus_valid;
    logic [7:0]  bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_wr_n;
    logic        bus_ready;
    logic [7:0]  bus_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    bus_arbiter #(
        .N_CLIENTS (4),
        .ADDR_W    (8),
        .DATA_W    (8),
        .TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rq        (rq),
        .cl_addr   (cl_addr),
        .cl_wdata  (cl_wdata),
        .cl_wr_ni  (cl_wr_ni),
        .gnt       (gnt),
        .ack       (ack),
        .rdata     (rdata),
        .err       (err),
        .bus_valid (bus_valid),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wr_n  (bus_wr_n),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, got running, want finished");
        $fatal(1, "watchdog expired");
    end

    // One per-cycle vector: inputs applied before a clock edge, and the
    // outputs required after that edge.
    typedef struct {
        logic [3:0] rq;
        logic       rdy;
        logic [7:0] brd;
        logic [3:0] e_gnt;
        logic [3:0] e_ack;
        logic       e_valid;
        logic [7:0] e_rdata;   // compared only when e_ack != 0
        logic       e_err;     // compared only when e_ack != 0
        logic [7:0] e_addr;    // compared only when e_valid
        logic [7:0] e_wdata;   // compared only when e_valid
        logic       e_wr_n;    // compared only when e_valid
    } vec_t;

    vec_t vecs [N_VEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Assert reset on a falling edge and hold it for two cycles. Release it
    // on a falling edge with all request inputs idle.
    task automatic do_reset();
        @(negedge clk);
        rstn      = 1'b0;
        rq        = 4'b0000;
        bus_ready = 1'b0;
        bus_rdata = 8'h00;
        step();
        step();
        rstn = 1'b1;
    endtask

    initial begin
        int n;
        int acks;
        int phase;
        int cl;
        logic [3:0] exp_gnt;
        logic [3:0] exp_ack;

        // Fixed per-client fields: {client3, client2, client1, client0}.
        cl_addr   = {8'h7C, 8'h5C, 8'h3C, 8'h0C};
        cl_wdata  = {8'h3E, 8'h2E, 8'h7E, 8'h1E};
        cl_wr_ni  = 4'b1101;   // only client 1 writes
        rstn      = 1'b0;
        rq        = 4'b0000;
        bus_ready = 1'b0;
        bus_rdata = 8'h00;

        //            rq       rdy   brd     gnt      ack      vld   rdata  err   addr   wdata  wr_n
        vecs[0]  = '{4'b0100, 1'b0, 8'h00, 4'b0100, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1}; // GRANT c2
        vecs[1]  = '{4'b0000, 1'b0, 8'h00, 4'b0100, 4'b0000, 1'b1, 8'h00, 1'b0, 8'h5C, 8'h2E, 1'b1}; // XFER
        vecs[2]  = '{4'b0000, 1'b1, 8'hA5, 4'b0100, 4'b0100, 1'b0, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b1}; // ACK
        vecs[3]  = '{4'b0000, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1}; // RECOVER
        vecs[4]  = '{4'b0000, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1}; // IDLE
        vecs[5]  = '{4'b0010, 1'b0, 8'h00, 4'b0010, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1}; // GRANT c1
        vecs[6]  = '{4'b0000, 1'b1, 8'hFF, 4'b0010, 4'b0000, 1'b1, 8'h00, 1'b0, 8'h3C, 8'h7E, 1'b0}; // ready in GRANT ignored
        vecs[7]  = '{4'b0000, 1'b0, 8'h00, 4'b0010, 4'b0000, 1'b1, 8'h00, 1'b0, 8'h3C, 8'h7E, 1'b0}; // XFER 2
        vecs[8]  = '{4'b0000, 1'b0, 8'h00, 4'b0010, 4'b0000, 1'b1, 8'h00, 1'b0, 8'h3C, 8'h7E, 1'b0}; // XFER 3
        vecs[9]  = '{4'b0000, 1'b0, 8'h00, 4'b0010, 4'b0000, 1'b1, 8'h00, 1'b0, 8'h3C, 8'h7E, 1'b0}; // XFER 4
        vecs[10] = '{4'b0000, 1'b1, 8'h11, 4'b0010, 4'b0010, 1'b0, 8'h11, 1'b0, 8'h00, 8'h00, 1'b0}; // ACK
        vecs[11] = '{4'b1000, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0}; // RECOVER, rq ignored
        vecs[12] = '{4'b1000, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0}; // IDLE, rq ignored
        vecs[13] = '{4'b1000, 1'b0, 8'h00, 4'b1000, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0}; // GRANT c3
        vecs[14] = '{4'b0000, 1'b0, 8'h00, 4'b1000, 4'b0000, 1'b1, 8'h00, 1'b0, 8'h7C, 8'h3E, 1'b1}; // rq dropped
        vecs[15] = '{4'b0000, 1'b1, 8'h3C, 4'b1000, 4'b1000, 1'b0, 8'h3C, 1'b0, 8'h00, 8'h00, 1'b1}; // ACK c3
        vecs[16] = '{4'b0000, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1}; // RECOVER
        vecs[17] = '{4'b0000, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1}; // IDLE
        vecs[18] = '{4'b0000, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1}; // no re-grant
        vecs[19] = '{4'b0011, 1'b0, 8'h00, 4'b0001, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1}; // wrap to c0
        vecs[20] = '{4'b0011, 1'b0, 8'h00, 4'b0001, 4'b0000, 1'b1, 8'h00, 1'b0, 8'h0C, 8'h1E, 1'b1}; // XFER
        vecs[21] = '{4'b0011, 1'b1, 8'h5A, 4'b0001, 4'b0001, 1'b0, 8'h5A, 1'b0, 8'h00, 8'h00, 1'b1}; // ACK
        vecs[22] = '{4'b0011, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1}; // RECOVER
        vecs[23] = '{4'b0011, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1}; // IDLE
        vecs[24] = '{4'b0011, 1'b0, 8'h00, 4'b0010, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1}; // c1 next

        // ---------------- reset values ----------------
        do_reset();
        check("rst gnt",       32'(gnt),       32'h0);
        check("rst ack",       32'(ack),       32'h0);
        check("rst rdata",     32'(rdata),     32'h0);
        check("rst err",       32'(err),       32'h0);
        check("rst bus_valid", 32'(bus_valid), 32'h0);
        check("rst bus_addr",  32'(bus_addr),  32'h0);
        check("rst bus_wdata", 32'(bus_wdata), 32'h0);
        check("rst bus_wr_n",  32'(bus_wr_n),  32'h1);

        // ---------------- vector table ----------------
        for (int i = 0; i < N_VEC; i++) begin
            rq        = vecs[i].rq;
            bus_ready = vecs[i].rdy;
            bus_rdata = vecs[i].brd;
            step();
            check($sformatf("v%0d gnt", i),       32'(gnt),       32'(vecs[i].e_gnt));
            check($sformatf("v%0d ack", i),       32'(ack),       32'(vecs[i].e_ack));
            check($sformatf("v%0d bus_valid", i), 32'(bus_valid), 32'(vecs[i].e_valid));
            if (vecs[i].e_ack != 4'b0000) begin
                check($sformatf("v%0d rdata", i), 32'(rdata), 32'(vecs[i].e_rdata));
                check($sformatf("v%0d err", i),   32'(err),   32'(vecs[i].e_err));
            end
            if (vecs[i].e_valid) begin
                check($sformatf("v%0d bus_addr", i),  32'(bus_addr),  32'(vecs[i].e_addr));
                check($sformatf("v%0d bus_wdata", i), 32'(bus_wdata), 32'(vecs[i].e_wdata));
                check($sformatf("v%0d bus_wr_n", i),  32'(bus_wr_n),  32'(vecs[i].e_wr_n));
            end
        end

        // ---------------- round robin, all requesting, ready immediate ----------------
        // Each transfer takes 5 cycles: GRANT, XFER, ACK, RECOVER, IDLE.
        // Grants must come in the order 0, 1, 2, 3, 0.
        do_reset();
        rq        = 4'b1111;
        bus_ready = 1'b1;
        bus_rdata = 8'h42;
        acks      = 0;
        for (int t = 1; t <= 25; t++) begin
            step();
            phase   = (t - 1) % 5;
            cl      = ((t - 1) / 5) % 4;
            exp_gnt = (phase <= 2) ? 4'(1 << cl) : 4'b0000;
            exp_ack = (phase == 2) ? 4'(1 << cl) : 4'b0000;
            check($sformatf("rr t%0d gnt", t), 32'(gnt), 32'(exp_gnt));
            check($sformatf("rr t%0d ack", t), 32'(ack), 32'(exp_ack));
            acks += $countones(ack);
        end
        check("rr ack count", 32'(acks), 32'd5);

        // ---------------- timeout, then the next requester ----------------
        do_reset();
        rq        = 4'b0101;
        bus_ready = 1'b0;
        bus_rdata = 8'hEE;
        step();
        check("to gnt", 32'(gnt), 32'b0001);
        n = 0;
        step();
        while (bus_valid === 1'b1 && n < 40) begin
            n++;
            step();
        end
        check("to valid cycles", 32'(n), 32'(TO));
        check("to ack",   32'(ack),   32'b0001);
        check("to err",   32'(err),   32'h1);
        check("to rdata", 32'(rdata), 32'h0);
        check("to gnt held", 32'(gnt), 32'b0001);
        bus_ready = 1'b1;
        bus_rdata = 8'h77;
        step();   // RECOVER
        step();   // IDLE
        step();   // GRANT
        check("after to gnt", 32'(gnt), 32'b0100);
        step();   // XFER
        check("after to valid", 32'(bus_valid), 32'h1);
        step();   // ACK
        check("after to ack",   32'(ack),   32'b0100);
        check("after to err",   32'(err),   32'h0);
        check("after to rdata", 32'(rdata), 32'h77);

        // ---------------- ready in the last allowed cycle ----------------
        rq        = 4'b0001;
        bus_ready = 1'b0;
        bus_rdata = 8'hC3;
        step();   // RECOVER
        step();   // IDLE
        step();   // GRANT
        check("last gnt", 32'(gnt), 32'b0001);
        step();   // first bus_valid cycle
        for (int k = 0; k < TO - 1; k++) begin
            step();
        end
        check("last valid 16th", 32'(bus_valid), 32'h1);
        bus_ready = 1'b1;
        step();
        check("last ack",   32'(ack),   32'b0001);
        check("last err",   32'(err),   32'h0);
        check("last rdata", 32'(rdata), 32'hC3);
        bus_ready = 1'b0;
        rq        = 4'b0000;

        // ---------------- reset during XFER ----------------
        do_reset();
        rq = 4'b0100;
        step();
        check("mid gnt", 32'(gnt), 32'b0100);
        rq = 4'b0000;
        step();
        check("mid valid", 32'(bus_valid), 32'h1);
        bus_ready = 1'b1;
        bus_rdata = 8'h99;
        rstn      = 1'b0;
        #1;
        check("mid rst gnt",       32'(gnt),       32'h0);
        check("mid rst ack",       32'(ack),       32'h0);
        check("mid rst bus_valid", 32'(bus_valid), 32'h0);
        check("mid rst bus_addr",  32'(bus_addr),  32'h0);
        check("mid rst bus_wdata", 32'(bus_wdata), 32'h0);
        check("mid rst bus_wr_n",  32'(bus_wr_n),  32'h1);
        check("mid rst rdata",     32'(rdata),     32'h0);
        check("mid rst err",       32'(err),       32'h0);
        step();
        check("mid hold ack 1", 32'(ack), 32'h0);
        step();
        check("mid hold ack 2", 32'(ack), 32'h0);
        rstn      = 1'b1;
        rq        = 4'b1111;
        bus_ready = 1'b0;
        step();
        check("mid post gnt", 32'(gnt), 32'b0001);
        check("mid post ack", 32'(ack), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
